mips_prog_loader: RTL and testbench

- Writer side of the processor's instruction memory. Accepts decoded instruction fields over a valid/ready stream and encodes them into the 32-bit format the pipeline decodes. Also masks unused fields and rejects opcodes the core does not execute.
- Encoded words pass through a small FIFO and are written to sequential word addresses of the shared memory. A HLT word (0xFC000000) is appended automatically, so test programs load before the core is released.

---
 rtl/mips_prog_loader.sv | 114 +++++++++++
 tb/tb_mips_prog_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: encodes instruction fields, buffers them, writes them to sequential memory words and appends HLT
module mips_prog_loader #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   words_written,
    output logic              done,
    output logic              err_illegal,
    output logic              err_ovf
);
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HALT_WR, DONE} state_t;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] TOP = '1;
    localparam logic [31:0] HLT = 32'hFC00_0000;
    state_t state;
    logic [31:0] fifo [FIFO_DEPTH];
    logic [PW:0] wp, rp;
    logic [31:0] enc;
    logic legal, mem_full, empty, full, xfer, complete, full_next, issue;
    assign empty = wp == rp;
    assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign in_ready = (state == LOAD) && !full;
    assign xfer = in_valid && in_ready;
    assign complete = mem_we && mem_ready;
    assign full_next = mem_full || (complete && mem_addr == TOP);
    assign issue = (state == LOAD || state == DRAIN) && !empty && (!mem_we || mem_ready);
    always_comb begin
        legal = 1'b1;
        enc = {in_op, 26'b0};
        if (in_op <= 6'h09) enc = {in_op, in_rs, in_rt, in_rd, 11'b0};
        else if (in_op >= 6'h10 && in_op <= 6'h14) enc = {in_op, in_rs, in_rt, in_imm};
        else if (in_op == 6'h15) enc = {in_op, in_rs, 21'b0};
        else if (in_op == 6'h16) enc = {in_op, 10'b0, in_imm};
        else if (in_op == 6'h17 || in_op == 6'h18) enc = {in_op, in_rs, 5'b0, in_imm};
        else legal = (in_op == 6'h3F);
    end
    always_ff @(posedge clk) begin
        if (xfer && legal) fifo[wp[PW-1:0]] <= enc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wp <= '0;
            rp <= '0;
            mem_full <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            words_written <= '0;
            done <= 1'b0;
            err_illegal <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            mem_full <= full_next;
            if (xfer && legal) wp <= wp + 1'b1;
            if (xfer && !legal) err_illegal <= 1'b1;
            if (complete) begin
                mem_we <= 1'b0;
                words_written <= words_written + 1'b1;
                if (mem_addr != TOP) mem_addr <= mem_addr + 1'b1;
            end
            if (issue) begin
                rp <= rp + 1'b1;
                mem_we <= !full_next;
                if (!full_next) mem_wdata <= fifo[rp[PW-1:0]];
                else err_ovf <= 1'b1;
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state <= LOAD;
                    mem_addr <= base_addr;
                    words_written <= '0;
                    done <= 1'b0;
                    err_illegal <= 1'b0;
                    err_ovf <= 1'b0;
                    mem_full <= 1'b0;
                end
                LOAD: if (finish) state <= DRAIN;
                DRAIN: if (empty && (!mem_we || mem_ready)) begin
                    if (full_next) begin
                        state <= DONE;
                        done <= 1'b1;
                        err_ovf <= 1'b1;
                    end else begin
                        state <= HALT_WR;
                        mem_we <= 1'b1;
                        mem_wdata <= HLT;
                    end
                end
                HALT_WR: if (complete) begin
                    state <= DONE;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: directed and randomized checks of the program loader against a field-level reference model
module tb_mips_prog_loader;
    localparam int ADDR_W = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_WORDS = 1 << ADDR_W;
    localparam logic [31:0] HLT_W = 32'hFC00_0000;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic in_ready, mem_we, mem_ready, done, err_illegal, err_ovf;
    logic [ADDR_W-1:0] base_addr = '0, mem_addr;
    logic [5:0] in_op = '0;
    logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [31:0] mem_wdata;
    logic [ADDR_W:0] words_written;
    logic rdy_mode = 1'b0, rdy_fix = 1'b1, rnd_bit = 1'b1;
    bit gap_mode = 1'b0;
    int checks = 0, errors = 0;
    logic [41:0] wr_log[$];
    logic [31:0] exp_words[$];
    bit exp_ill;
    int log_start, cur_base;
    int legal_ops[21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21, 22, 23, 24, 63, 0};
    assign mem_ready = rdy_mode ? rnd_bit : rdy_fix;
    always #5 clk = ~clk;
    always @(negedge clk) rnd_bit = ($urandom_range(0, 2) != 0);
    always @(posedge clk) if (mem_we && mem_ready) wr_log.push_back({mem_addr, mem_wdata});
    mips_prog_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .words_written(words_written),
        .done(done), .err_illegal(err_illegal), .err_ovf(err_ovf)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [32:0] ref_enc(input int op, input int rs, input int rt, input int rd, input int imm);
        bit u_rs = 0, u_rt = 0, u_rd = 0, u_imm = 0, ok = 1;
        longint w;
        if (op <= 9) begin u_rs = 1; u_rt = 1; u_rd = 1; end
        else if (op >= 16 && op <= 20) begin u_rs = 1; u_rt = 1; u_imm = 1; end
        else if (op == 21) u_rs = 1;
        else if (op == 22) u_imm = 1;
        else if (op == 23 || op == 24) begin u_rs = 1; u_imm = 1; end
        else if (op != 63) ok = 0;
        w = longint'(op) * (64'd1 << 26) + (u_rs ? longint'(rs) * (64'd1 << 21) : 0)
          + (u_rt ? longint'(rt) * (64'd1 << 16) : 0) + (u_rd ? longint'(rd) * (64'd1 << 11) : 0)
          + (u_imm ? longint'(imm) : 0);
        return {ok, w[31:0]};
    endfunction
    function automatic int rand_op(input bit only_legal);
        if (only_legal || $urandom_range(0, 3) != 0) return legal_ops[$urandom_range(0, 19)];
        return $urandom_range(0, 63);
    endfunction
    task automatic do_start(input int b);
        exp_words.delete();
        exp_ill = 0;
        cur_base = b;
        log_start = wr_log.size();
        base_addr = ADDR_W'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask
    task automatic do_finish();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask
    task automatic send(input int op, input int rs, input int rt, input int rd, input int imm);
        logic [32:0] r;
        int n = 0;
        r = ref_enc(op, rs, rt, rd, imm);
        if (gap_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm);
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (r[32]) exp_words.push_back(r[31:0]);
        else exp_ill = 1;
    endtask
    task automatic send_rand(input bit only_legal);
        send(rand_op(only_legal), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
    endtask
    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin @(posedge clk); #1; n++; end
        chk("done", done, 1);
    endtask
    task automatic check_load(input string tag);
        int n, room, nw, total, avail;
        bit hlt;
        logic [41:0] e;
        n = exp_words.size();
        room = MEM_WORDS - cur_base;
        nw = n < room ? n : room;
        hlt = n < room;
        total = nw + int'(hlt);
        avail = wr_log.size() - log_start;
        chk({tag, "_nwrites"}, avail, total);
        for (int i = 0; i < total && i < avail; i++) begin
            e = wr_log[log_start + i];
            chk({tag, "_addr"}, e[41:32], cur_base + i);
            chk({tag, "_data"}, e[31:0], i < nw ? exp_words[i] : HLT_W);
        end
        chk({tag, "_words_written"}, words_written, total);
        chk({tag, "_err_ovf"}, err_ovf, !hlt);
        chk({tag, "_err_illegal"}, err_illegal, exp_ill);
        chk({tag, "_mem_we_idle"}, mem_we, 0);
        chk({tag, "_in_ready_idle"}, in_ready, 0);
    endtask
    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_words_written"}, words_written, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_illegal"}, err_illegal, 0);
        chk({tag, "_err_ovf"}, err_ovf, 0);
    endtask
    initial begin
        int k;
        bit acc, seen;
        logic [ADDR_W-1:0] a0;
        logic [31:0] d0;
        logic [41:0] e;
        int op_a[8], rs_a[8], rt_a[8], rd_a[8], im_a[8];
        logic [32:0] r;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(0);
        chk("t1_in_ready", in_ready, 1);
        send(0, 1, 2, 3, 16'hFFFF);
        chk("t1_latency_we0", mem_we, 0);
        @(posedge clk); #1;
        chk("t1_latency_we1", mem_we, 1);
        chk("t1_add_word", mem_wdata, 32'h0022_1800);
        chk("t1_add_addr", mem_addr, 0);
        do_finish();
        wait_done();
        check_load("t1");
        do_start(10);
        send(8'h12, 4, 0, 0, 16'h0005);
        send(8'h16, 7, 0, 0, 16'h0010);
        send(8'h17, 2, 9, 0, 16'hFFFE);
        do_finish();
        wait_done();
        check_load("t2");
        e = wr_log[log_start];
        chk("t2_adi", e[31:0], 32'h4880_0005);
        e = wr_log[log_start + 1];
        chk("t2_jpi", e[31:0], 32'h5800_0010);
        e = wr_log[log_start + 2];
        chk("t2_bif", e[31:0], 32'h5C40_FFFE);
        do_start(20);
        send_rand(1);
        send(8'h0C, 1, 2, 3, 16'h1234);
        send_rand(1);
        do_finish();
        wait_done();
        chk("t3_err_illegal", err_illegal, 1);
        check_load("t3");
        rdy_fix = 1'b0;
        do_start(100);
        for (int i = 0; i < 8; i++) begin
            op_a[i] = rand_op(1); rs_a[i] = $urandom_range(0, 31); rt_a[i] = $urandom_range(0, 31);
            rd_a[i] = $urandom_range(0, 31); im_a[i] = $urandom_range(0, 65535);
        end
        k = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = k < 8;
            if (k < 8) begin
                in_op = 6'(op_a[k]); in_rs = 5'(rs_a[k]); in_rt = 5'(rt_a[k]); in_rd = 5'(rd_a[k]); in_imm = 16'(im_a[k]);
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                r = ref_enc(op_a[k], rs_a[k], rt_a[k], rd_a[k], im_a[k]);
                exp_words.push_back(r[31:0]);
                k++;
            end
            if (seen) begin
                chk("stall_addr_stable", mem_addr, a0);
                chk("stall_data_stable", mem_wdata, d0);
            end else if (mem_we) begin
                seen = 1;
                a0 = mem_addr;
                d0 = mem_wdata;
            end
        end
        in_valid = 1'b0;
        chk("stall_accepts", k, FIFO_DEPTH + 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_mem_we", mem_we, 1);
        chk("stall_first_addr", a0, 100);
        chk("stall_first_data", d0, exp_words[0]);
        rdy_fix = 1'b1;
        for (int j = k; j < 8; j++) send(op_a[j], rs_a[j], rt_a[j], rd_a[j], im_a[j]);
        do_finish();
        wait_done();
        check_load("stall");
        do_start(1022);
        repeat (3) send_rand(1);
        do_finish();
        wait_done();
        chk("ovf_words_written", words_written, 2);
        chk("ovf_err", err_ovf, 1);
        check_load("ovf");
        rdy_fix = 1'b0;
        do_start(200);
        repeat (4) send_rand(1);
        do_finish();
        @(posedge clk); #1;
        chk("rst_pre_mem_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_drain");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_fix = 1'b1;
        do_start(300);
        send_rand(1);
        do_finish();
        wait_done();
        check_load("rst_after");
        rdy_mode = 1'b1;
        gap_mode = 1'b1;
        for (int it = 0; it < 6; it++) begin
            do_start(it % 3 == 2 ? $urandom_range(1016, 1023) : $urandom_range(0, 900));
            repeat ($urandom_range(0, 10)) send_rand(0);
            do_finish();
            wait_done();
            check_load("rand");
        end
        rdy_mode = 1'b0;
        gap_mode = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
